// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encodings, iteration constants and helpers for multdiv
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    // Magnitude of a two's complement word; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_counter_6.sv
// rtl/multdiv_counter_6.sv - 6-bit iteration counter with synchronous clear and enable
module counter_6
    import multdiv_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;

    // Clear has priority over counting so a restart always begins from zero.
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative 32-bit signed Booth multiplier / restoring divider
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t           state_q;
    logic             op_mult_q;
    logic             neg_q;
    logic             div_zero_q;
    logic             div_ovf_q;
    // Accumulator / partial remainder; one guard bit above 32 so that
    // subtracting a multiplicand of -2^31 cannot overflow.
    logic [32:0]      acc_q;
    logic [31:0]      q_q;
    logic             qm1_q;
    logic [31:0]      m_q;
    logic [31:0]      result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;
    logic [CNT_W-1:0] iter_cnt;

    logic             start;
    logic [32:0]      booth_sum;
    logic [32:0]      rem_sh;
    logic [33:0]      trial;
    logic [32:0]      acc_d;
    logic [31:0]      q_d;
    logic             qm1_d;
    logic [63:0]      prod;
    logic [31:0]      res_d;
    logic             exc_d;

    assign start = ctrl_MULT | ctrl_DIV;

    counter_6 u_iter_cnt (
        .clk_i   (clock),
        .reset_i (reset),
        .clr_i   (start),
        .en_i    (state_q == ST_RUN),
        .count_o (iter_cnt)
    );

    // One iteration step of the active operation, plus the final result formed from that step.
    always_comb begin
        booth_sum = acc_q;
        rem_sh    = {acc_q[31:0], q_q[31]};
        trial     = {1'b0, rem_sh} - {2'b00, m_q};
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        prod      = '0;
        res_d     = '0;
        exc_d     = 1'b0;
        if (op_mult_q) begin
            case ({q_q[0], qm1_q})
                2'b01:   booth_sum = acc_q + {m_q[31], m_q};
                2'b10:   booth_sum = acc_q - {m_q[31], m_q};
                default: booth_sum = acc_q;
            endcase
            acc_d = {booth_sum[32], booth_sum[32:1]};
            q_d   = {booth_sum[0], q_q[31:1]};
            qm1_d = q_q[0];
            prod  = {acc_d[31:0], q_d};
            res_d = prod[31:0];
            exc_d = ~((&prod[63:31]) | ~(|prod[63:31]));
        end else begin
            if (!trial[33]) begin
                acc_d = trial[32:0];
                q_d   = {q_q[30:0], 1'b1};
            end else begin
                acc_d = rem_sh;
                q_d   = {q_q[30:0], 1'b0};
            end
            if (div_zero_q) begin
                res_d = '0;
            end else begin
                res_d = neg_q ? (~q_d + 32'd1) : q_d;
            end
            exc_d = div_zero_q | div_ovf_q;
        end
    end

    // Control FSM and datapath registers; a start edge in any state restarts the operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_mult_q  <= 1'b0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else if (start) begin
            state_q    <= ST_RUN;
            op_mult_q  <= ctrl_MULT;
            busy_q     <= 1'b1;
            rdy_q      <= 1'b0;
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            neg_q      <= data_operandA[31] ^ data_operandB[31];
            div_zero_q <= (data_operandB == 32'h0);
            div_ovf_q  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            if (ctrl_MULT) begin
                q_q <= data_operandB;
                m_q <= data_operandA;
            end else begin
                q_q <= abs32(data_operandA);
                m_q <= abs32(data_operandB);
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    if (iter_cnt == LAST_ITER) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= res_d;
                        exc_q    <= exc_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - self-checking bench for multdiv
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;
    int rdy_pulses = 0;

    bit          chk_en = 1'b0;
    int          m_left = 0;
    bit          m_mult = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] exp_res = '0;
    logic        exp_exc = 1'b0;
    logic        exp_rdy = 1'b0;
    logic        exp_busy = 1'b0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of the operation: {exception, result}.
    function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint     p;
        logic [63:0] pv;
        if (mul) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pv = p;
            return {(p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000), pv[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        p  = longint'($signed(a)) / longint'($signed(b));
        pv = p;
        return {1'b0, pv[31:0]};
    endfunction

    // Cycle-level expectation: 32 busy cycles after a start, then one ready cycle.
    always @(posedge clock) begin
        chk_en = 1'b1;
        if (reset) begin
            m_left   = 0;
            exp_res  = '0;
            exp_exc  = 1'b0;
            exp_rdy  = 1'b0;
            exp_busy = 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_mult   = ctrl_MULT;
            m_a      = data_operandA;
            m_b      = data_operandB;
            m_left   = 32;
            exp_busy = 1'b1;
            exp_rdy  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {exp_exc, exp_res} = model(m_mult, m_a, m_b);
                exp_rdy  = 1'b1;
                exp_busy = 1'b0;
            end
        end else begin
            exp_rdy = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("resultRDY", {31'b0, data_resultRDY}, {31'b0, exp_rdy});
            check("result", data_result, exp_res);
            check("exception", {31'b0, data_exception}, {31'b0, exp_exc});
            if (data_resultRDY) rdy_pulses++;
        end
    end

    task automatic run_op(input string name, input bit mul, input bit div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input bit scramble);
        bit got;
        @(posedge clock); #1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mul;
        ctrl_DIV  = div;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                got = 1'b1;
                check({name, " latency"}, i, 33);
                check({name, " result"}, data_result, er);
                check({name, " exception"}, {31'b0, data_exception}, {31'b0, ee});
            end else if (scramble) begin
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end
        if (!got) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s timeout: got no resultRDY expected one within 40 cycles", name);
        end
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset result", data_result, 32'h0);
        check("reset busy/rdy/exc", {29'b0, busy, data_resultRDY, data_exception}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_op("mul 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("mul max*2", 1, 0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 0);
        run_op("mul min*1", 1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 0);
        run_op("mul min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 0);
        run_op("mul -1*-1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'h0, 1'b1, 0);
        run_op("div min/1", 0, 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 0);
        run_op("div -100/-7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 0);
        run_op("div 7/-100", 0, 1, 32'd7, 32'hFFFF_FF9C, 32'h0, 1'b0, 0);

        // Divide aborted by a multiply start at cycle 10.
        p0 = rdy_pulses;
        @(posedge clock); #1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        run_op("abort mul 6*7", 1, 0, 32'd6, 32'd7, 32'd42, 1'b0, 0);
        check("abort single pulse", rdy_pulses - p0, 32'd1);

        // Reset mid-run.
        @(posedge clock); #1;
        data_operandA = 32'd123;
        data_operandB = 32'd456;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (14) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrun reset result", data_result, 32'h0);
        check("midrun reset busy/rdy/exc", {29'b0, busy, data_resultRDY, data_exception}, 32'h0);
        p0 = rdy_pulses;
        repeat (40) @(negedge clock);
        check("no pulse after reset", rdy_pulses - p0, 32'd0);
        run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);

        // Both controls high with operands changing during RUN.
        run_op("both ctrl -5*9", 1, 1, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFD3, 1'b0, 1);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
